// File: rtl/serial_frame_recv_if.sv
// rtl/serial_frame_recv_if.sv - handshake/bus bundle for the serial frame receiver
// Purpose: groups the bit strobe, serial line, consumer handshake, counter clear
//          and all receiver outputs into one interface.
// Modports:
//   master - drives I_BIT_EN, I_SERIAL_DATA, I_READY, I_CLR_CNT; observes outputs
//   slave  - the receiver side: consumes the I_* signals, drives O_DATA, O_VALID,
//            O_PARITY_ERR, O_FRAME_ERR, O_OVERRUN, O_ERR_CNT
interface serial_frame_recv_if #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 I_BIT_EN;
  logic                 I_SERIAL_DATA;
  logic                 I_READY;
  logic                 I_CLR_CNT;
  logic [DATA_W-1:0]    O_DATA;
  logic                 O_VALID;
  logic                 O_PARITY_ERR;
  logic                 O_FRAME_ERR;
  logic                 O_OVERRUN;
  logic [ERR_CNT_W-1:0] O_ERR_CNT;

  modport master (
    output I_BIT_EN, I_SERIAL_DATA, I_READY, I_CLR_CNT,
    input  O_DATA, O_VALID, O_PARITY_ERR, O_FRAME_ERR, O_OVERRUN, O_ERR_CNT
  );

  modport slave (
    input  I_BIT_EN, I_SERIAL_DATA, I_READY, I_CLR_CNT,
    output O_DATA, O_VALID, O_PARITY_ERR, O_FRAME_ERR, O_OVERRUN, O_ERR_CNT
  );
endinterface

// File: rtl/serial_frame_recv.sv
// rtl/serial_frame_recv.sv - serial frame receiver with parity/stop checking and error count
// Purpose: samples a start/data/parity/stop serial line on I_BIT_EN strobes, presents
//          good payloads through a valid/ready holding register, pulses error flags
//          and keeps a saturating count of errored or dropped frames.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - serial_frame_recv_if.slave (line, strobe, handshake, counter clear, outputs)
module serial_frame_recv #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_frame_recv_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RESYNC
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 acc_q, acc_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic sample;
  logic done;
  logic good;
  logic bad;
  logic drop;
  logic load;

  assign sample = bus.I_SERIAL_DATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame sequencing; everything here advances only on strobe cycles.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    if (bus.I_BIT_EN) begin
      case (state_q)
        S_IDLE: begin
          if (!sample) begin
            state_d = S_DATA;
            idx_d   = '0;
            acc_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        S_DATA: begin
          shift_d[idx_q] = sample;
          acc_d          = acc_q ^ sample;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_PARITY: begin
          perr_d  = (PARITY_MODE == 2) ? ~(acc_q ^ sample) : (acc_q ^ sample);
          state_d = S_STOP;
        end
        S_STOP: begin
          // ferr_d already folds in the current sample, so the final stop bit counts.
          ferr_d = ferr_q | ~sample;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = ferr_d ? S_RESYNC : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_RESYNC: begin
          if (sample) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output register, handshake and error accounting.
  always_comb begin
    good    = done & ~perr_q & ~ferr_d;
    bad     = done & (perr_q | ferr_d);
    drop    = good & valid_q & ~bus.I_READY;
    load    = good & ~drop;
    data_d  = load ? shift_q : data_q;
    valid_d = load | (valid_q & ~bus.I_READY);
    pe_d    = done & perr_q;
    fe_d    = done & ferr_d;
    ov_d    = drop;
    cnt_d   = cnt_q;
    if (bus.I_CLR_CNT) begin
      cnt_d = '0;
    end else if ((bad | drop) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign bus.O_DATA       = data_q;
  assign bus.O_VALID      = valid_q;
  assign bus.O_PARITY_ERR = pe_q;
  assign bus.O_FRAME_ERR  = fe_q;
  assign bus.O_OVERRUN    = ov_q;
  assign bus.O_ERR_CNT    = cnt_q;
endmodule

// File: tb/tb_serial_frame_recv.sv
// tb/tb_serial_frame_recv.sv - scoreboard bench for serial_frame_recv over three configurations
module tb_serial_frame_recv;
  typedef struct {
    logic        pe;
    logic        fe;
    logic        ov;
    logic        cons;
    logic [15:0] data;
    logic        valid;
    int          cnt;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst  [3];
  logic        en   [3];
  logic        ser  [3];
  logic        rdy  [3];
  logic        clr  [3];
  logic [15:0] o_data  [3];
  logic        o_valid [3];
  logic        o_pe    [3];
  logic        o_fe    [3];
  logic        o_ov    [3];
  logic [7:0]  o_cnt   [3];

  int cfg_dw   [3] = '{8, 8, 7};
  int cfg_pm   [3] = '{1, 1, 2};
  int cfg_sb   [3] = '{1, 1, 2};
  int cfg_cmax [3] = '{255, 3, 255};

  serial_frame_recv_if #(.DATA_W(8), .ERR_CNT_W(8)) b0 ();
  serial_frame_recv_if #(.DATA_W(8), .ERR_CNT_W(2)) b1 ();
  serial_frame_recv_if #(.DATA_W(7), .ERR_CNT_W(8)) b2 ();

  serial_frame_recv #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .ERR_CNT_W(8))
    u0 (.clk(clk), .rst(rst[0]), .bus(b0));
  serial_frame_recv #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .ERR_CNT_W(2))
    u1 (.clk(clk), .rst(rst[1]), .bus(b1));
  serial_frame_recv #(.DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2), .ERR_CNT_W(8))
    u2 (.clk(clk), .rst(rst[2]), .bus(b2));

  assign b0.I_BIT_EN = en[0];  assign b0.I_SERIAL_DATA = ser[0];
  assign b0.I_READY  = rdy[0]; assign b0.I_CLR_CNT     = clr[0];
  assign b1.I_BIT_EN = en[1];  assign b1.I_SERIAL_DATA = ser[1];
  assign b1.I_READY  = rdy[1]; assign b1.I_CLR_CNT     = clr[1];
  assign b2.I_BIT_EN = en[2];  assign b2.I_SERIAL_DATA = ser[2];
  assign b2.I_READY  = rdy[2]; assign b2.I_CLR_CNT     = clr[2];

  assign o_data[0] = 16'(b0.O_DATA); assign o_valid[0] = b0.O_VALID;
  assign o_pe[0] = b0.O_PARITY_ERR;  assign o_fe[0] = b0.O_FRAME_ERR;
  assign o_ov[0] = b0.O_OVERRUN;     assign o_cnt[0] = 8'(b0.O_ERR_CNT);
  assign o_data[1] = 16'(b1.O_DATA); assign o_valid[1] = b1.O_VALID;
  assign o_pe[1] = b1.O_PARITY_ERR;  assign o_fe[1] = b1.O_FRAME_ERR;
  assign o_ov[1] = b1.O_OVERRUN;     assign o_cnt[1] = 8'(b1.O_ERR_CNT);
  assign o_data[2] = 16'(b2.O_DATA); assign o_valid[2] = b2.O_VALID;
  assign o_pe[2] = b2.O_PARITY_ERR;  assign o_fe[2] = b2.O_FRAME_ERR;
  assign o_ov[2] = b2.O_OVERRUN;     assign o_cnt[2] = 8'(b2.O_ERR_CNT);

  // Reference model: what the consumer should observe, per instance.
  ev_t         sbq    [3][$];
  int          m_cnt  [3];
  logic        m_pend [3];
  logic [15:0] m_last [3];

  int   n_tot   = 0;
  int   n_bad   = 0;
  int   rc_req  = 0;
  int   rc_inst = 0;
  logic fin_req = 1'b0;

  task automatic model_reset(input int k);
    m_cnt[k]  = 0;
    m_pend[k] = 1'b0;
    m_last[k] = '0;
  endtask

  function automatic int bump(input int k, input logic clr_now);
    if (clr_now) return 0;
    return (m_cnt[k] < cfg_cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
  endfunction

  task automatic model_complete(input int k, input logic [15:0] d, input logic bad_par,
                                input logic bad_fr, input logic clr_now);
    ev_t e;
    e.pe = bad_par; e.fe = bad_fr; e.ov = 1'b0; e.cons = 1'b0;
    e.valid = m_pend[k]; e.cyc = cyc; e.data = m_last[k];
    if (bad_par || bad_fr) begin
      m_cnt[k] = bump(k, clr_now);
    end else if (m_pend[k] && !rdy[k]) begin
      e.ov = 1'b1;
      m_cnt[k] = bump(k, clr_now);
    end else if (rdy[k]) begin
      m_last[k] = d; e.cons = 1'b1; e.valid = 1'b1; e.data = d;
      if (clr_now) m_cnt[k] = 0;
    end else begin
      m_pend[k] = 1'b1; m_last[k] = d;
      if (clr_now) m_cnt[k] = 0;
      return;
    end
    e.cnt = m_cnt[k];
    sbq[k].push_back(e);
  endtask

  task automatic set_ready(input int k, input logic r);
    ev_t e;
    rdy[k] = r;
    if (r && m_pend[k]) begin
      m_pend[k] = 1'b0;
      e.pe = 1'b0; e.fe = 1'b0; e.ov = 1'b0; e.cons = 1'b1;
      e.data = m_last[k]; e.valid = 1'b1; e.cnt = m_cnt[k]; e.cyc = -1;
      sbq[k].push_back(e);
    end
  endtask

  // One line bit, sampled by a single strobe on the div-th cycle.
  task automatic drive_bit(input int k, input logic b, input int div, input logic clr_now);
    ser[k] = b;
    for (int i = 1; i < div; i++) begin
      en[k] = 1'b0;
      @(posedge clk); #1;
    end
    en[k] = 1'b1; clr[k] = clr_now;
    @(posedge clk); #1;
    en[k] = 1'b0; clr[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n, input int div);
    for (int i = 0; i < n; i++) drive_bit(k, 1'b1, div, 1'b0);
  endtask

  task automatic send_frame(input int k, input logic [15:0] data, input logic par_flip,
                            input logic stop_bad, input int div, input logic clr_end);
    logic [15:0] d;
    logic [15:0] mask;
    logic        p;
    logic        last;
    mask = (16'h1 << cfg_dw[k]) - 16'h1;
    d = data & mask;
    p = 1'b0;
    drive_bit(k, 1'b0, div, 1'b0);
    for (int i = 0; i < cfg_dw[k]; i++) begin
      drive_bit(k, d[i], div, 1'b0);
      p = p ^ d[i];
    end
    if (cfg_pm[k] != 0) drive_bit(k, ((cfg_pm[k] == 2) ? ~p : p) ^ par_flip, div, 1'b0);
    for (int s = 0; s < cfg_sb[k]; s++) begin
      last = (s == cfg_sb[k] - 1);
      drive_bit(k, !(stop_bad && last), div, clr_end && last);
    end
    model_complete(k, d, par_flip && (cfg_pm[k] != 0), stop_bad, clr_end);
  endtask

  task automatic req_reset_check(input int k);
    rc_inst = k;
    rc_req++;
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", name, k, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int  rc_seen;
    int  flags;
    ev_t e;
    rc_seen = 0;
    forever begin
      @(negedge clk);
      if (rc_req != rc_seen) begin
        rc_seen = rc_req;
        chk("reset_data", rc_inst, int'(o_data[rc_inst]), 0);
        chk("reset_valid", rc_inst, int'(o_valid[rc_inst]), 0);
        chk("reset_pulses", rc_inst, int'({o_pe[rc_inst], o_fe[rc_inst], o_ov[rc_inst]}), 0);
        chk("reset_cnt", rc_inst, int'(o_cnt[rc_inst]), 0);
      end
      for (int k = 0; k < 3; k++) begin
        flags = int'({o_pe[k], o_fe[k], o_ov[k], o_valid[k] && rdy[k]});
        if (!rst[k] && flags != 0) begin
          if (sbq[k].size() == 0) begin
            chk("unexpected_event", k, flags, 0);
          end else begin
            e = sbq[k].pop_front();
            chk("event_flags", k, flags, int'({e.pe, e.fe, e.ov, e.cons}));
            chk("data", k, int'(o_data[k]), int'(e.data));
            chk("valid", k, int'(o_valid[k]), int'(e.valid));
            chk("err_cnt", k, int'(o_cnt[k]), e.cnt);
            if (e.cyc >= 0) chk("latency_cycle", k, cyc, e.cyc);
          end
        end
      end
      if (fin_req || cyc > 80000) begin
        if (!fin_req) chk("timeout_cycle", 0, cyc, 80000);
        for (int k = 0; k < 3; k++) chk("queue_drained", k, sbq[k].size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
      end
    end
  end

  initial begin : stim
    int k;
    int div;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; ser[i] = 1'b1; rdy[i] = 1'b1; clr[i] = 1'b0;
      model_reset(i);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int i = 0; i < 3; i++) req_reset_check(i);

    // Good frame, parity error, then frame error followed by a long break.
    send_frame(0, 16'hA5, 1'b0, 1'b0, 1, 1'b0); idle(0, 2, 1);
    send_frame(0, 16'hA5, 1'b1, 1'b0, 1, 1'b0); idle(0, 2, 1);
    send_frame(0, 16'h3C, 1'b0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(0, 1'b0, 1, 1'b0);
    idle(0, 2, 1);
    send_frame(0, 16'h5A, 1'b0, 1'b0, 1, 1'b0); idle(0, 2, 1);

    // Overrun: second frame lands while the first is still unconsumed.
    set_ready(0, 1'b0);
    send_frame(0, 16'h11, 1'b0, 1'b0, 1, 1'b0); idle(0, 1, 1);
    send_frame(0, 16'h22, 1'b0, 1'b0, 1, 1'b0); idle(0, 1, 1);
    set_ready(0, 1'b1); idle(0, 2, 1);

    // Narrow counter saturation, then clear racing an error.
    for (int i = 0; i < 5; i++) begin
      send_frame(1, 16'h40 + 16'(i), 1'b1, 1'b0, 1, 1'b0); idle(1, 1, 1);
    end
    send_frame(1, 16'h99, 1'b1, 1'b0, 1, 1'b1); idle(1, 1, 1);

    // Odd parity, two stop bits, sparse strobe, reset mid-data.
    drive_bit(2, 1'b0, 4, 1'b0);
    drive_bit(2, 1'b1, 4, 1'b0);
    drive_bit(2, 1'b0, 4, 1'b0);
    rst[2] = 1'b1;
    model_reset(2);
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    req_reset_check(2);
    send_frame(2, 16'h55, 1'b0, 1'b0, 4, 1'b0); idle(2, 1, 4);

    // Randomised frames across all three configurations.
    for (int n = 0; n < 45; n++) begin
      k = n % 3;
      div = (k == 2) ? 4 : int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) set_ready(k, !rdy[k]);
      send_frame(k, 16'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 div, $urandom_range(0, 9) == 0);
      idle(k, int'($urandom_range(1, 3)), div);
    end
    for (int i = 0; i < 3; i++) set_ready(i, 1'b1);
    for (int w = 0; w < 200 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; w++)
      @(posedge clk);
    #1;
    fin_req = 1'b1;
  end
endmodule
